// File: rtl/lsu_axi_sram.sv
// AXI4-Lite data memory behind the load/store unit: one transaction at a time, fixed response
// latency, and narrow accesses realigned to the low byte lanes. Define RAND_DELAY_EN for LFSR latency jitter.
module lsu_axi_sram #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          RD_LATENCY = 2,
  parameter int          WR_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_RESP = 3'd2,
    WR_DATA = 3'd3,
    WR_WAIT = 3'd4,
    WR_RESP = 3'd5
  } state_e;

  localparam int          WORDS    = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN     = 33'd4 << DEPTH_LOG2;
  localparam logic [4:0]  RD_LAT_C = 5'(RD_LATENCY);
  localparam logic [4:0]  WR_LAT_C = 5'(WR_LATENCY);
  localparam logic [1:0]  RESP_OK  = 2'b00;
  localparam logic [1:0]  RESP_ERR = 2'b10;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        bvalid_q, bvalid_d;
  logic        mem_we_s;
  logic [4:0]  jitter_s;

  logic [31:0] mem_q [WORDS];

  logic [31:0]           offset_s;
  logic                  in_range_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic [1:0]            sh_s;
  logic [31:0]           wdata_sh_s;
  logic [3:0]            wstrb_sh_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign offset_s   = addr_q - BASE_ADDR;
  assign in_range_s = ({1'b0, offset_s} < SPAN);
  assign idx_s      = offset_s[DEPTH_LOG2+1:2];
  assign sh_s       = offset_s[1:0];
  // Lane shift moves narrow data up to its byte position; strobes pushed past lane 3 fall off.
  assign wdata_sh_s = wdata << {sh_s, 3'b000};
  assign wstrb_sh_s = wstrb << sh_s;

  assign arready = (state_q == IDLE);
  assign awready = (state_q == IDLE) && !arvalid;
  assign wready  = (state_q == WR_DATA);

  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rvalid = rvalid_q;
  assign bresp  = bresp_q;
  assign bvalid = bvalid_q;

`ifdef RAND_DELAY_EN
  logic [15:0] lfsr_q;

  // Free-running Fibonacci LFSR, taps 16,14,13,11, used as latency jitter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign jitter_s = {2'b00, lfsr_q[2:0]};
`else
  assign jitter_s = 5'd0;
`endif

  // State, counter, latched address and registered response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      addr_q   <= 32'd0;
      rdata_q  <= 32'd0;
      rresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rvalid_q <= rvalid_d;
      bresp_q  <= bresp_d;
      bvalid_q <= bvalid_d;
    end
  end

  // Next-state and response logic for the single-outstanding transaction FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    bresp_d  = bresp_q;
    bvalid_d = bvalid_q;
    mem_we_s = 1'b0;

    case (state_q)
      IDLE: begin
        // Read has priority; a concurrent AW simply waits for the next IDLE.
        if (arvalid) begin
          addr_d  = araddr;
          cnt_d   = RD_LAT_C + jitter_s;
          state_d = RD_WAIT;
        end else if (awvalid) begin
          addr_d  = awaddr;
          state_d = WR_DATA;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 5'd0) begin
          rvalid_d = 1'b1;
          state_d  = RD_RESP;
          if (in_range_s) begin
            rdata_d = mem_q[idx_s] >> {sh_s, 3'b000};
            rresp_d = RESP_OK;
          end else begin
            rdata_d = 32'd0;
            rresp_d = RESP_ERR;
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      RD_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      WR_DATA: begin
        if (wvalid) begin
          mem_we_s = in_range_s;
          cnt_d    = WR_LAT_C + jitter_s;
          state_d  = WR_WAIT;
        end else begin
          state_d = WR_DATA;
        end
      end
      WR_WAIT: begin
        if (cnt_q == 5'd0) begin
          bvalid_d = 1'b1;
          bresp_d  = in_range_s ? RESP_OK : RESP_ERR;
          state_d  = WR_RESP;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      WR_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Storage array; deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= merge_bytes(mem_q[idx_s], wdata_sh_s, wstrb_sh_s);
    end
  end

endmodule

// File: doc/lsu_axi_sram.md
Name: lsu_axi_sram

Overview:
- AXI4-Lite slave memory directly downstream of the core's load/store unit; consumes its AR/R/AW/W/B channels and returns load data and write responses.
- Single outstanding transaction, fixed programmable response latency, byte-lane realignment so narrow loads/stores travel in the low lanes.
- Used as data memory in simulation and in the FPGA build.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH_LOG2, 12, log2 of the number of 32-bit words.
- RD_LATENCY, 2, wait cycles between the AR handshake and rvalid (0..15).
- WR_LATENCY, 1, wait cycles between W acceptance and bvalid (0..15).

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- araddr in 32 / arvalid in 1 / arready out 1  read address channel
- rdata out 32 / rresp out 2 / rvalid out 1 / rready in 1  read data channel
- awaddr in 32 / awvalid in 1 / awready out 1  write address channel
- wdata in 32 / wstrb in 4 / wvalid in 1 / wready out 1  write data channel
- bresp out 2 / bvalid out 1 / bready in 1  write response channel

Behaviour:
- Reset (reset low, any time, mid-transaction included): state=IDLE, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, latency counter=0. Memory contents are not cleared. An aborted write leaves memory untouched unless the write commit already happened.
- Ready signals are combinational:
  - arready = (state==IDLE)
  - awready = (state==IDLE) && !arvalid
  - wready = (state==WR_DATA)
- States: IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_WAIT, WR_RESP.
- IDLE:
  - arvalid → latch araddr, counter=RD_LATENCY, go to RD_WAIT.
  - Otherwise awvalid → latch awaddr, go to WR_DATA.
  - Simultaneous arvalid and awvalid: the read wins. AW stays pending and is taken on the next return to IDLE.
- RD_WAIT: decrement counter each cycle. At zero, load rdata, set rvalid=1, go to RD_RESP. Net result: rvalid rises RD_LATENCY+1 cycles after the AR handshake edge.
- RD_RESP: hold rvalid, rdata and rresp stable until rready. The handshake cycle clears rvalid and returns to IDLE.
- WR_DATA: on wvalid, commit the write in that cycle, counter=WR_LATENCY, go to WR_WAIT. W is never accepted before AW.
- WR_WAIT: count down as for reads. At zero, set bvalid=1 and go to WR_RESP.
- WR_RESP: hold bvalid and bresp until bready. The handshake clears bvalid and returns to IDLE.
- Address decode:
  - offset = addr - BASE_ADDR
  - in range if offset < 4<<DEPTH_LOG2
  - word index = offset[DEPTH_LOG2+1:2], sh = offset[1:0]
- Read data: rdata = mem[index] >> (8*sh), zero-filled in the upper bits. Load-unit sign/zero extension is applied downstream.
- Write data: byte lane i of the word is written with (wdata << 8*sh) lane i when (wstrb << sh)[i] is set. Strobe bits shifted beyond bit 3 are dropped; no straddling access.
- Out of range:
  - Read: rresp=2'b10 (SLVERR), rdata=0.
  - Write: bresp=2'b10, memory unchanged.
  - In range: rresp/bresp=2'b00.
- Read-after-write to the same address in back-to-back transactions returns the new data.

Optional Feature:
- Macro RAND_DELAY_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 on reset, advancing every cycle.
  - On each AR or W acceptance, lfsr[2:0] (0..7) is added to the loaded latency count.
  - Used to stress the load unit's handshakes.
- Undefined: no LFSR logic; latency is exactly RD_LATENCY / WR_LATENCY.

Test Plan:
- Word round trip: write addr 0x8000_0010, data 0xDEADBEEF, wstrb 0xF, then read the same address → bresp 0, rdata 0xDEADBEEF, rresp 0; rvalid exactly 3 cycles after the AR handshake (defaults, RAND_DELAY_EN off).
- Byte store: mem word 0x11223344 at 0x8000_0020; write wdata 0x000000AA, wstrb 0x1, addr 0x8000_0022 → word becomes 0x11AA3344. Then read 0x8000_0022 → rdata 0x000011AA.
- Out of range: read 0x7FFF_FFFC → rresp 2'b10, rdata 0. Write 0x8000_4000 → bresp 2'b10, with no memory word changed.
- Simultaneous arvalid and awvalid in IDLE → read completes first; awready low until rvalid/rready. The write then completes with bresp 0.
- Backpressure: hold rready=0 for 5 cycles after rvalid → rvalid and rdata stable throughout; the next AR is not accepted until the handshake.
- Reset mid read (reset low in RD_WAIT) → rvalid=0 and arready=1 immediately after release. A subsequent read returns correct data.
